pulse_gen: RTL and testbench

Programmable pulse-train generator: the transmit counterpart of the pulse period/width measurement path. Drives a single-bit pulse output with a configured period and high-width, both in `clk` cycles, so that a pulse train can be produced and looped back into the measurement block. Configuration is double-buffered and changes only on a period boundary, so the output never carries a truncated or glitched cycle.

---
 rtl/pulse_gen.sv | 183 ++++++++++++++++++
 tb/tb_pulse_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_gen.sv
// Programmable pulse-train generator with double-buffered period/width/burst config.
// Define PULSE_GEN_BURST_EN to honour burst_n (HOLD state and done strobe); default is continuous.
module pulse_gen #(
    parameter int W  = 32,
    parameter int BW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          load,
    input  logic [W-1:0]  period_in,
    input  logic [W-1:0]  width_in,
    input  logic [BW-1:0] burst_n,
    output logic          pulse,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

`ifdef PULSE_GEN_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t        state_q,      state_d;
    logic [W-1:0]  cnt_q,        cnt_d;
    logic [BW-1:0] brem_q,       brem_d;
    logic          pulse_q,      pulse_d;
    logic          busy_q,       busy_d;
    logic          done_q,       done_d;
    logic          cfg_err_q,    cfg_err_d;

    logic [W-1:0]  sh_period_q,  sh_period_d;
    logic [W-1:0]  sh_width_q,   sh_width_d;
    logic [BW-1:0] sh_burst_q,   sh_burst_d;
    logic          sh_pend_q,    sh_pend_d;
    logic [W-1:0]  act_period_q, act_period_d;
    logic [W-1:0]  act_width_q,  act_width_d;
    logic [BW-1:0] act_burst_q,  act_burst_d;
    logic          act_valid_q,  act_valid_d;

    // Config that will be in force after this edge's shadow transfer (if any).
    logic [W-1:0]  eff_width;
    logic [BW-1:0] eff_burst;
    logic          xfer;
    logic          ld_rej;
    logic          ld_clamp;

    assign eff_width = sh_pend_q ? sh_width_q : act_width_q;
    assign eff_burst = sh_pend_q ? sh_burst_q : act_burst_q;
    assign ld_rej    = load && (period_in < W'(2));
    assign ld_clamp  = load && !ld_rej && (width_in >= period_in);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        brem_d       = brem_q;
        done_d       = 1'b0;
        cfg_err_d    = cfg_err_q;
        sh_period_d  = sh_period_q;
        sh_width_d   = sh_width_q;
        sh_burst_d   = sh_burst_q;
        sh_pend_d    = sh_pend_q;
        act_period_d = act_period_q;
        act_width_d  = act_width_q;
        act_burst_d  = act_burst_q;
        act_valid_d  = act_valid_q;
        xfer         = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                xfer  = sh_pend_q;
                if (ena && (act_valid_q || sh_pend_q)) begin
                    cnt_d   = W'(1);
                    state_d = (eff_width == '0) ? LOW : HIGH;
                    brem_d  = eff_burst;
                end
            end
            HIGH: begin
                cnt_d = cnt_q + W'(1);
                if (cnt_q == act_width_q) state_d = LOW;
            end
            LOW: begin
                if (cnt_q == act_period_q) begin
                    xfer = sh_pend_q;
                    if (!ena) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (BURST_EN && (brem_q == BW'(1))) begin
                        done_d  = 1'b1;
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = W'(1);
                        state_d = (eff_width == '0) ? LOW : HIGH;
                        // brem of 0 means continuous and is never decremented.
                        if (brem_q != '0) brem_d = brem_q - BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end
            HOLD: begin
                cnt_d = '0;
                if (!ena) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (xfer) begin
            act_period_d = sh_period_q;
            act_width_d  = sh_width_q;
            act_burst_d  = sh_burst_q;
            act_valid_d  = 1'b1;
            sh_pend_d    = 1'b0;
        end

        // A load landing on the transfer edge stays pending for the next boundary.
        if (load) begin
            cfg_err_d = ld_rej || ld_clamp;
            if (!ld_rej) begin
                sh_period_d = period_in;
                sh_width_d  = ld_clamp ? (period_in - W'(1)) : width_in;
                sh_burst_d  = burst_n;
                sh_pend_d   = 1'b1;
            end
        end

        pulse_d = (state_d == HIGH);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            brem_q       <= '0;
            pulse_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            sh_period_q  <= '0;
            sh_width_q   <= '0;
            sh_burst_q   <= '0;
            sh_pend_q    <= 1'b0;
            act_period_q <= '0;
            act_width_q  <= '0;
            act_burst_q  <= '0;
            act_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            brem_q       <= brem_d;
            pulse_q      <= pulse_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
            sh_period_q  <= sh_period_d;
            sh_width_q   <= sh_width_d;
            sh_burst_q   <= sh_burst_d;
            sh_pend_q    <= sh_pend_d;
            act_period_q <= act_period_d;
            act_width_q  <= act_width_d;
            act_burst_q  <= act_burst_d;
            act_valid_q  <= act_valid_d;
        end
    end

    assign pulse   = pulse_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Bench for pulse_gen: vector table, directed multi-cycle sequences, randomized reconfiguration vs. a waveform model.
module tb_pulse_gen;
    localparam int W  = 32;
    localparam int BW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ena = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  period_in = '0;
    logic [W-1:0]  width_in = '0;
    logic [BW-1:0] burst_n = '0;
    logic          pulse, busy, done, cfg_err;

    int n_chk  = 0;
    int n_pass = 0;

    pulse_gen #(.W(W), .BW(BW)) dut (
        .clk(clk), .rst(rst), .ena(ena), .load(load),
        .period_in(period_in), .width_in(width_in), .burst_n(burst_n),
        .pulse(pulse), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ena;
        logic load;
        int   p;
        int   w;
        logic ep;
        logic eb;
        logic ee;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Train cycle k (1-based from the start of a period run) is high when its offset is below width.
    function automatic int ref_bit(input int k, input int p, input int w);
        return (((k - 1) % p) < w) ? 1 : 0;
    endfunction

    function automatic int weff(input int p, input int w);
        return (w >= p) ? p - 1 : w;
    endfunction

    task automatic do_load(input int p, input int w, input int b);
        period_in = p;
        width_in  = w;
        burst_n   = b;
        load      = 1'b1;
        step();
        load      = 1'b0;
    endtask

    task automatic stop_wait();
        ena = 1'b0;
        for (int i = 0; i < 40 && busy; i++) step();
        chk("stop_idle", busy, 0);
        chk("stop_pulse", pulse, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pa, wa, pb, wb, j, m, n, e;
        bit acc_b;

        // vector table: reset idle, load 10/3, run 30 cycles with a rejected load at cycle 22
        tbl.push_back('{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 10, 3, 1'b0, 1'b0, 1'b0});
        for (int k = 1; k <= 30; k++) begin
            tbl.push_back('{1'b1, (k == 22), (k == 22) ? 1 : 10, 5,
                            ref_bit(k, 10, 3) != 0, 1'b1, (k >= 22)});
        end

        step();
        chk("rst_pulse", pulse, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", cfg_err, 0);
        step();
        rst = 1'b1;

        foreach (tbl[i]) begin
            ena       = tbl[i].ena;
            load      = tbl[i].load;
            period_in = tbl[i].p;
            width_in  = tbl[i].w;
            step();
            chk($sformatf("vec%0d_pulse", i), pulse, tbl[i].ep);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].eb);
            chk($sformatf("vec%0d_err", i), cfg_err, tbl[i].ee);
        end
        load = 1'b0;
        stop_wait();

        // clamp: 5/9 runs as 4 high, 1 low; a later valid load clears the flag
        do_load(5, 9, 0);
        chk("clamp_err", cfg_err, 1);
        ena = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("clamp_pulse", pulse, ref_bit(k, 5, 4));
        end
        stop_wait();
        do_load(6, 2, 0);
        chk("clear_err", cfg_err, 0);

        // reconfiguration mid-run: 6/2 loaded in cycle 4 of a 10/3 period
        do_load(10, 3, 0);
        ena = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            step();
            chk("reconf_pulse", pulse, (k <= 10) ? ref_bit(k, 10, 3) : ref_bit(k - 10, 6, 2));
            chk("reconf_done", done, 0);
            if (k == 5) load = 1'b0;
            if (k == 4) begin
                period_in = 6;
                width_in  = 2;
                load      = 1'b1;
            end
        end
        stop_wait();

        // width 0: constant low while busy
        do_load(7, 0, 0);
        ena = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("w0_pulse", pulse, 0);
            chk("w0_busy", busy, 1);
        end
        stop_wait();

        // ena dropped in cycle 2: the 10/3 period completes, then idle
        do_load(10, 3, 0);
        ena = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k <= 10) begin
                chk("drop_pulse", pulse, ref_bit(k, 10, 3));
                chk("drop_busy", busy, 1);
            end else begin
                chk("drop_idle_busy", busy, 0);
                chk("drop_idle_pulse", pulse, 0);
            end
            if (k == 2) ena = 1'b0;
        end

`ifdef PULSE_GEN_BURST_EN
        // burst of 3 periods of 4/1, then HOLD until ena toggles
        do_load(4, 1, 3);
        ena = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("burst_pulse", pulse, (k <= 12) ? ref_bit(k, 4, 1) : 0);
            chk("burst_done", done, (k == 13) ? 1 : 0);
            chk("burst_busy", busy, 1);
        end
        ena = 1'b0;
        step();
        chk("burst_hold_exit", busy, 0);
        ena = 1'b1;
        step();
        chk("burst_restart", pulse, 1);
        stop_wait();
`endif

        // randomized: config A, then config B (possibly rejected/clamped) loaded mid-run
        for (int r = 0; r < 20; r++) begin
            pa = $urandom_range(12, 2);
            wa = $urandom_range(pa + 2, 0);
            pb = $urandom_range(12, 0);
            wb = $urandom_range(pb + 2, 0);
            j  = $urandom_range(3 * pa, 1);
            acc_b = (pb >= 2);
            m  = (j / pa + 1) * pa;
            n  = m + 27;
            do_load(pa, wa, 0);
            chk("rnd_err_a", cfg_err, (wa >= pa) ? 1 : 0);
            ena = 1'b1;
            for (int k = 1; k <= n; k++) begin
                step();
                if (acc_b && k > m) e = ref_bit(k - m, pb, weff(pb, wb));
                else e = ref_bit(k, pa, weff(pa, wa));
                chk($sformatf("rnd%0d_pulse_k%0d", r, k), pulse, e);
                if (k == j + 1) begin
                    load = 1'b0;
                    chk("rnd_err_b", cfg_err, (pb < 2 || wb >= pb) ? 1 : 0);
                end
                if (k == j) begin
                    period_in = pb;
                    width_in  = wb;
                    burst_n   = '0;
                    load      = 1'b1;
                end
            end
            stop_wait();
        end

        // async reset in the middle of HIGH; afterwards nothing starts without a config
        do_load(10, 3, 0);
        ena = 1'b1;
        step();
        step();
        chk("pre_rst_pulse", pulse, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_pulse", pulse, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        step();
        rst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("post_rst_pulse", pulse, 0);
            chk("post_rst_busy", busy, 0);
        end
        ena = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
